// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t      - ownership state (IDLE, OWN0, OWN1)
//   mst_idx_t        - master index (0 = CPU data port, 1 = debug/loader)
//   LOCK_MAX_DEFAULT - default bound on consecutive grants under contention
//   DATA_W           - data-memory word width
//   other_master()   - index of the opposite master
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic mst_idx_t;

  localparam int LOCK_MAX_DEFAULT = 16;
  localparam int DATA_W           = 32;

  function automatic mst_idx_t other_master(input mst_idx_t m);
    return ~m;
  endfunction

endpackage

// File: rtl/dmem_lock_ctr.sv
// dmem_lock_ctr: counts grants within one ownership episode.
//   clk, rst_n - clock, synchronous active-low reset
//   clr        - return count to zero (any entry to IDLE)
//   inc        - a grant happened this cycle
//   expire     - the grant in this cycle is (at least) the LOCK_MAX-th of the
//                episode; the owner must yield if the other master is waiting
// The count saturates at LOCK_MAX so an uncontended owner can keep the lock
// indefinitely.
module dmem_lock_ctr
  import dmem_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(LOCK_MAX);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != MAX_C)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // cnt_reg holds the grants already taken; the current one makes cnt_reg+1.
  assign expire = (cnt_reg >= (MAX_C - 1'b1));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU data port
// (master 0) and the debug/program loader (master 1).
//   clk, rst_n              - clock, synchronous active-low reset
//   mX_req/we/lock/adr/wdata - master X access request (held until granted)
//   mX_gnt                  - access performed this cycle (combinational)
//   mX_rvalid, mX_rdata     - registered read return, one cycle after grant
//   mem_adr/mem_wdin/mem_we - to the DRAM wrapper (writes on falling edge)
//   mem_rd                  - combinational read data from the DRAM wrapper
// Round-robin on ties; a master may lock the port for a burst, bounded by
// LOCK_MAX grants while the other master is waiting.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [31:0]       m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [31:0]       m1_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_wdin,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  arb_state_t state_reg, state_next;
  mst_idx_t   ptr_reg, ptr_next;   // last granted master

  logic [1:0]        req_vec, we_vec, lock_vec, gnt_vec, rvalid_vec;
  logic [ADDR_W-1:0] adr_arr   [2];
  logic [DATA_W-1:0] wdata_arr [2];
  logic [DATA_W-1:0] rdata_arr [2];

  logic     gnt_any;
  mst_idx_t gnt_idx;
  logic     ctr_clr, ctr_expire;

  assign req_vec      = {m1_req, m0_req};
  assign we_vec       = {m1_we, m0_we};
  assign lock_vec     = {m1_lock, m0_lock};
  assign adr_arr[0]   = m0_adr;
  assign adr_arr[1]   = m1_adr;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;

  assign gnt_any = |gnt_vec;
  assign gnt_idx = gnt_vec[1];     // grants are one-hot

  // Grant and next-state logic.
  always_comb begin
    gnt_vec    = 2'b00;
    state_next = IDLE;
    ptr_next   = ptr_reg;

    case (state_reg)
      IDLE: begin
        if (&req_vec) begin
          gnt_vec[other_master(ptr_reg)] = 1'b1;
        end else begin
          gnt_vec = req_vec;
        end
      end
      // The owner only; the other master waits for IDLE even if owner idles.
      OWN0:    gnt_vec[0] = req_vec[0];
      OWN1:    gnt_vec[1] = req_vec[1];
      default: gnt_vec = 2'b00;
    endcase

    // No access may slip through while reset is asserted.
    if (!rst_n) begin
      gnt_vec = 2'b00;
    end

    if (gnt_any) begin
      ptr_next = gnt_idx;
      // Keep ownership only if requested and the burst bound is not hit
      // while the other master waits; ptr_next then favours the other.
      if (lock_vec[gnt_idx] && !(ctr_expire && req_vec[other_master(gnt_idx)])) begin
        state_next = gnt_idx ? OWN1 : OWN0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign ctr_clr = (state_next == IDLE);

  dmem_lock_ctr #(
    .LOCK_MAX (LOCK_MAX)
  ) u_lock_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ctr_clr),
    .inc    (gnt_any),
    .expire (ctr_expire)
  );

  // Memory port mux; idle port is driven to all-zero.
  always_comb begin
    mem_we   = 1'b0;
    mem_adr  = '0;
    mem_wdin = '0;
    if (gnt_any) begin
      mem_we   = we_vec[gnt_idx];
      mem_adr  = adr_arr[gnt_idx];
      mem_wdin = wdata_arr[gnt_idx];
    end
  end

  // Per-master read return registers.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic        rvalid_reg;
      logic [31:0] rdata_reg;
      logic        rd_hit;

      assign rd_hit = gnt_vec[gi] & ~we_vec[gi];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= rd_hit;
          if (rd_hit) begin
            rdata_reg <= mem_rd;
          end
        end
      end

      assign rvalid_vec[gi] = rvalid_reg;
      assign rdata_arr[gi]  = rdata_reg;
    end
  endgenerate

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign m0_rvalid = rvalid_vec[0];
  assign m1_rvalid = rvalid_vec[1];
  assign m0_rdata  = rdata_arr[0];
  assign m1_rdata  = rdata_arr[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// behavioural model (ownership/turn bookkeeping plus a shadow memory).
module tb_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_adr, m0_wdata, m1_adr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, mem_adr, mem_wdin, mem_rd;
  logic        mem_we;

  dmem_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_adr(mem_adr), .mem_wdin(mem_wdin), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  // Distributed-RAM stand-in: combinational read, falling-edge write.
  logic [31:0] dram [256] = '{default: 32'h0};
  always @(negedge clk) if (mem_we) dram[mem_adr[9:2]] <= mem_wdin;
  assign mem_rd = dram[mem_adr[9:2]];

  // ---------------- reference model ----------------
  logic [31:0] shadow [256] = '{default: 32'h0};
  int          m_owner = -1;   // -1: nobody holds the port
  int          m_burst = 0;    // grants taken in the current ownership
  int          m_last  = 1;    // last granted master
  bit          exp_g  [2];
  bit          exp_we;
  logic [31:0] exp_adr, exp_wd;
  bit          exp_rv [2];
  logic [31:0] exp_rd [2];
  int          checks = 0;
  int          errors = 0;

  function automatic bit req_of(int m);  return (m == 0) ? m0_req  : m1_req;  endfunction
  function automatic bit we_of(int m);   return (m == 0) ? m0_we   : m1_we;   endfunction
  function automatic bit lock_of(int m); return (m == 0) ? m0_lock : m1_lock; endfunction
  function automatic logic [31:0] adr_of(int m); return (m == 0) ? m0_adr : m1_adr; endfunction
  function automatic logic [31:0] wd_of(int m);  return (m == 0) ? m0_wdata : m1_wdata; endfunction

  // Who should win this cycle, and what the memory port should carry.
  task automatic model_eval();
    exp_g[0] = 0; exp_g[1] = 0;
    if (rst_n) begin
      if (m_owner < 0) begin
        if (req_of(0) && req_of(1)) exp_g[1 - m_last] = 1;
        else if (req_of(0))         exp_g[0] = 1;
        else if (req_of(1))         exp_g[1] = 1;
      end else begin
        exp_g[m_owner] = req_of(m_owner);
      end
    end
    exp_we = 0; exp_adr = 32'h0; exp_wd = 32'h0;
    for (int m = 0; m < 2; m++) begin
      if (exp_g[m]) begin
        exp_we = we_of(m); exp_adr = adr_of(m); exp_wd = wd_of(m);
      end
    end
  endtask

  // Apply the effects of the cycle just clocked.
  task automatic model_commit();
    if (!rst_n) begin
      m_owner = -1; m_burst = 0; m_last = 1;
      exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    end else begin
      exp_rv[0] = 0; exp_rv[1] = 0;
      if (!exp_g[0] && !exp_g[1]) begin
        m_owner = -1; m_burst = 0;
      end
      for (int m = 0; m < 2; m++) begin
        if (exp_g[m]) begin
          if (we_of(m)) shadow[adr_of(m)/4 % 256] = wd_of(m);
          else begin exp_rv[m] = 1; exp_rd[m] = shadow[adr_of(m)/4 % 256]; end
          m_last  = m;
          m_burst = (m_owner < 0) ? 1 : ((m_burst < LOCK_MAX) ? m_burst + 1 : LOCK_MAX);
          if (lock_of(m) && !(m_burst >= LOCK_MAX && req_of(1 - m))) m_owner = m;
          else begin m_owner = -1; m_burst = 0; end
        end
      end
    end
  endtask

  task automatic settle(); #1; model_eval(); endtask
  task automatic tick();   @(posedge clk); #1; model_commit(); endtask

  task automatic set_m(input int m, input bit rq, input bit we, input bit lk,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin m0_req = rq; m0_we = we; m0_lock = lk; m0_adr = a; m0_wdata = d; end
    else        begin m1_req = rq; m1_we = we; m1_lock = lk; m1_adr = a; m1_wdata = d; end
  endtask

  task automatic idle_all();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 0; idle_all(); settle(); tick(); rst_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    set_m(0, 1, 1, 1, 32'h4000, 32'hAAAA5555);
    set_m(1, 1, 1, 0, 32'h4004, 32'h5555AAAA);
    settle();
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt0 got=%b exp=0", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt1 got=%b exp=0", m1_gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    tick(); settle(); tick();
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", m1_rvalid, m0_rvalid); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", m0_rdata, m1_rdata); end
    idle_all(); rst_n = 1;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    set_m(0, 1, 1, 0, 32'h4000, 32'hDEADBEEF); settle(); tick();
    set_m(0, 1, 0, 0, 32'h4000, 32'h0); settle();
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL single_gnt got=%b%b exp=01", m1_gnt, m0_gnt); end
    checks++; if (mem_adr !== 32'h4000 || mem_we !== 1'b0) begin errors++; $display("FAIL single_port got=%h/%b exp=4000/0", mem_adr, mem_we); end
    tick();
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%b/%h exp=1/deadbeef", m0_rvalid, m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL single_m1_rvalid got=%b exp=0", m1_rvalid); end
    idle_all(); settle(); tick();
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold got=%b/%h exp=0/deadbeef", m0_rvalid, m0_rdata); end
    $display("test_single_read done");
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_m(0, 1, 0, 0, 32'h4000 + 32'(i*8), 32'h0);
      set_m(1, 1, 0, 0, 32'h4004 + 32'(i*8), 32'h0);
      settle();
      checks++;
      if (m0_gnt !== ((i % 2) == 0) || m1_gnt !== ((i % 2) == 1)) begin
        errors++; $display("FAIL alt_gnt i=%0d got=%b%b exp_m0=%0d", i, m1_gnt, m0_gnt, (i % 2) == 0);
      end
      tick();
      checks++; if (m0_rvalid !== ((i % 2) == 0)) begin errors++; $display("FAIL alt_rvalid i=%0d got=%b", i, m0_rvalid); end
    end
    idle_all(); settle(); tick();
    $display("test_alternate done");
  endtask

  task automatic test_lock_burst();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_m(1, 1, 0, 1, 32'h4020 + 32'(i*4), 32'h0);
      if (i > 0) set_m(0, 1, 0, 0, 32'h4040, 32'h0);
      settle();
      checks++;
      if (m1_gnt !== (i < 4) || m0_gnt !== (i == 4)) begin
        errors++; $display("FAIL lock_burst i=%0d got=%b%b exp_m1=%0d", i, m1_gnt, m0_gnt, i < 4);
      end
      tick();
    end
    idle_all(); settle(); tick();
    $display("test_lock_burst done");
  endtask

  task automatic test_write_then_read();
    set_m(0, 1, 1, 0, 32'h4010, 32'h12345678); settle();
    checks++; if (m0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdin !== 32'h12345678) begin errors++; $display("FAIL wr_port got=%b/%b/%h exp=1/1/12345678", m0_gnt, mem_we, mem_wdin); end
    tick();
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=0", m0_rvalid); end
    idle_all(); set_m(1, 1, 0, 0, 32'h4010, 32'h0); settle();
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%b exp=1", m1_gnt); end
    tick();
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h12345678) begin errors++; $display("FAIL wr_rd_data got=%b/%h exp=1/12345678", m1_rvalid, m1_rdata); end
    idle_all(); settle(); tick();
    $display("test_write_then_read done");
  endtask

  task automatic test_idle_mux();
    idle_all(); settle();
    checks++; if (mem_we !== 1'b0 || mem_adr !== 32'h0 || mem_wdin !== 32'h0) begin errors++; $display("FAIL idle_port got=%b/%h/%h exp=0/0/0", mem_we, mem_adr, mem_wdin); end
    tick();
    set_m(0, 1, 0, 1, 32'h4080, 32'h0); settle(); tick();                   // m0 takes lock
    set_m(1, 1, 1, 0, 32'h4090, 32'hCAFEF00D); settle();                      // m1 writes, m0 reads
    checks++; if (m1_gnt !== 1'b0 || mem_we !== 1'b0 || mem_adr !== 32'h4080) begin errors++; $display("FAIL owner_read got=%b/%b/%h exp=0/0/4080", m1_gnt, mem_we, mem_adr); end
    tick();
    set_m(0, 1, 1, 1, 32'h4084, 32'h0BADC0DE); settle();                      // owner writes
    checks++; if (mem_we !== 1'b1 || mem_wdin !== 32'h0BADC0DE || mem_adr !== 32'h4084) begin errors++; $display("FAIL owner_write got=%b/%h/%h exp=1/0badc0de/4084", mem_we, mem_wdin, mem_adr); end
    tick();
    set_m(0, 0, 0, 0, 32'h0, 32'h0); settle();                                // owner drops req
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL release_gap got=%b%b/%b exp=00/0", m1_gnt, m0_gnt, mem_we); end
    tick(); settle();
    checks++; if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdin !== 32'hCAFEF00D) begin errors++; $display("FAIL release_m1 got=%b/%b/%h exp=1/1/cafef00d", m1_gnt, mem_we, mem_wdin); end
    tick();
    idle_all(); settle(); tick();
    $display("test_idle_mux done");
  endtask

  task automatic test_reset_mid_lock();
    set_m(0, 1, 0, 1, 32'h4000, 32'h0); settle(); tick();
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL midlock_pre got=%h exp=deadbeef", m0_rdata); end
    rst_n = 0; set_m(1, 1, 0, 0, 32'h4004, 32'h0); settle();
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL midlock_gnt got=%b%b exp=00", m1_gnt, m0_gnt); end
    tick();
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL midlock_clear got=%b/%h exp=0/0", m0_rvalid, m0_rdata); end
    rst_n = 1; set_m(0, 1, 0, 0, 32'h4000, 32'h0); settle();
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL midlock_tie got=%b%b exp=01", m1_gnt, m0_gnt); end
    tick();
    idle_all(); settle(); tick();
    $display("test_reset_mid_lock done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int m = 0; m < 2; m++) begin
        if (!(req_of(m) && !exp_g[m])) begin   // a pending request is held
          set_m(m, $urandom_range(0, 99) < 65, $urandom_range(0, 1), $urandom_range(0, 99) < 70,
                32'h4000 + 32'($urandom_range(0, 63) * 4), $urandom);
        end
      end
      settle();
      checks++; if (m0_gnt !== exp_g[0]) begin errors++; $display("FAIL rnd_gnt0 c=%0d got=%b exp=%b", c, m0_gnt, exp_g[0]); end
      checks++; if (m1_gnt !== exp_g[1]) begin errors++; $display("FAIL rnd_gnt1 c=%0d got=%b exp=%b", c, m1_gnt, exp_g[1]); end
      checks++; if (mem_we !== exp_we || mem_adr !== exp_adr || mem_wdin !== exp_wd) begin
        errors++; $display("FAIL rnd_port c=%0d got=%b/%h/%h exp=%b/%h/%h", c, mem_we, mem_adr, mem_wdin, exp_we, exp_adr, exp_wd);
      end
      tick();
      checks++; if (m0_rvalid !== exp_rv[0] || m0_rdata !== exp_rd[0]) begin errors++; $display("FAIL rnd_rd0 c=%0d got=%b/%h exp=%b/%h", c, m0_rvalid, m0_rdata, exp_rv[0], exp_rd[0]); end
      checks++; if (m1_rvalid !== exp_rv[1] || m1_rdata !== exp_rd[1]) begin errors++; $display("FAIL rnd_rd1 c=%0d got=%b/%h exp=%b/%h", c, m1_rvalid, m1_rdata, exp_rv[1], exp_rd[1]); end
    end
    rst_n = 1; idle_all(); settle(); tick();
    $display("test_random done");
  endtask

  initial begin
    rst_n = 0;
    idle_all();
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_burst();
    test_write_then_read();
    test_idle_mux();
    test_reset_mid_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
